// File: rtl/bitser_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one bit-serial adder port between N_REQ streams.
// Grant is held from first to last flit; per-packet status is reported one cycle after completion.
module bitser_rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2,
    parameter int unsigned LEN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [N_REQ-1:0] i_req_A,
    input  logic [N_REQ-1:0] i_req_B,
    input  logic [N_REQ-1:0] i_req_vld,
    input  logic [N_REQ-1:0] i_req_last,
    output logic [N_REQ-1:0] o_req_rdy,
    output logic             o_A,
    output logic             o_B,
    output logic             o_vld,
    output logic             o_last,
    input  logic             i_rdy,
    output logic [ID_W-1:0]  o_id,
    input  logic             i_ovf,
    output logic             o_pkt_done,
    output logic [ID_W-1:0]  o_pkt_id,
    output logic [LEN_W-1:0] o_pkt_len,
    output logic             o_pkt_ovf
);

    typedef enum logic {StIdle = 1'b0, StBusy = 1'b1} state_e;

    localparam logic [ID_W-1:0] PtrRst = ID_W'(N_REQ - 1);

    state_e           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             pkt_done_q, pkt_done_d;
    logic [ID_W-1:0]  pkt_id_q, pkt_id_d;
    logic [LEN_W-1:0] pkt_len_q, pkt_len_d;
    logic             pkt_ovf_q, pkt_ovf_d;

    logic             arb_found;
    logic [ID_W-1:0]  arb_idx;
    logic [LEN_W-1:0] cnt_inc;
    logic             hs;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= StIdle;
            ptr_q      <= PtrRst;
            grant_q    <= '0;
            cnt_q      <= '0;
            pkt_done_q <= 1'b0;
            pkt_id_q   <= '0;
            pkt_len_q  <= '0;
            pkt_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            pkt_done_q <= pkt_done_d;
            pkt_id_q   <= pkt_id_d;
            pkt_len_q  <= pkt_len_d;
            pkt_ovf_q  <= pkt_ovf_d;
        end
    end

    // Search starts just past the last winner, so the previous owner has lowest priority.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = (32'(ptr_q) + i) % N_REQ;
            if (!arb_found && i_req_vld[cand[ID_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + LEN_W'(1);
    assign hs      = o_vld & i_rdy;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        pkt_done_d = 1'b0;
        pkt_id_d   = pkt_id_q;
        pkt_len_d  = pkt_len_q;
        pkt_ovf_d  = pkt_ovf_q;
        unique case (state_q)
            StIdle: begin
                if (arb_found) begin
                    grant_d = arb_idx;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (hs) begin
                    if (o_last) begin
                        pkt_done_d = 1'b1;
                        pkt_id_d   = grant_q;
                        pkt_len_d  = cnt_inc;
                        pkt_ovf_d  = i_ovf;
                        ptr_d      = grant_q;
                        cnt_d      = '0;
                        state_d    = StIdle;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_A       = 1'b0;
        o_B       = 1'b0;
        o_vld     = 1'b0;
        o_last    = 1'b0;
        o_req_rdy = '0;
        if (state_q == StBusy) begin
            o_A                = i_req_A[grant_q];
            o_B                = i_req_B[grant_q];
            o_vld              = i_req_vld[grant_q];
            o_last             = i_req_last[grant_q];
            o_req_rdy[grant_q] = i_rdy;
        end
    end

    assign o_id       = grant_q;
    assign o_pkt_done = pkt_done_q;
    assign o_pkt_id   = pkt_id_q;
    assign o_pkt_len  = pkt_len_q;
    assign o_pkt_ovf  = pkt_ovf_q;

endmodule

// File: tb/tb_bitser_rr_arbiter.sv
// Bench for bitser_rr_arbiter: a cycle table for the basic packet flow plus stream-driven
// sequences for arbitration order, stalls, mid-packet reset and length saturation.
module tb_bitser_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_a, req_b, req_vld, req_last;
    logic [3:0] req_rdy, req_rdy2;
    logic       o_a, o_b, o_vld, o_last, rdy, ovf;
    logic       o_a2, o_b2, o_vld2, o_last2;
    logic [1:0] o_id, o_id2, pkt_id, pkt_id2;
    logic       pkt_done, pkt_done2, pkt_ovf, pkt_ovf2;
    logic [7:0] pkt_len;
    logic [1:0] pkt_len2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bitser_rr_arbiter #(.N_REQ(4), .ID_W(2), .LEN_W(8)) u_dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req_A(req_a), .i_req_B(req_b), .i_req_vld(req_vld), .i_req_last(req_last),
        .o_req_rdy(req_rdy), .o_A(o_a), .o_B(o_b), .o_vld(o_vld), .o_last(o_last),
        .i_rdy(rdy), .o_id(o_id), .i_ovf(ovf),
        .o_pkt_done(pkt_done), .o_pkt_id(pkt_id), .o_pkt_len(pkt_len), .o_pkt_ovf(pkt_ovf)
    );

    // Same stimulus, narrow length counter to exercise saturation.
    bitser_rr_arbiter #(.N_REQ(4), .ID_W(2), .LEN_W(2)) u_dut_sat (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req_A(req_a), .i_req_B(req_b), .i_req_vld(req_vld), .i_req_last(req_last),
        .o_req_rdy(req_rdy2), .o_A(o_a2), .o_B(o_b2), .o_vld(o_vld2), .o_last(o_last2),
        .i_rdy(rdy), .o_id(o_id2), .i_ovf(ovf),
        .o_pkt_done(pkt_done2), .o_pkt_id(pkt_id2), .o_pkt_len(pkt_len2),
        .o_pkt_ovf(pkt_ovf2)
    );

    typedef struct {
        logic [3:0] vld, last, a, b;
        logic       rdy, ovf;
        logic       e_vld, e_last, e_a, e_b;
        logic [3:0] e_rdy;
        logic [1:0] e_id;
        logic       e_done;
        logic [1:0] e_pid;
        logic [7:0] e_len;
        logic       e_povf;
    } vec_t;

    vec_t tv[10];

    // Stream sources: per-requester packet length, packets left, flits left in current packet.
    int plen[4], pcnt[4], rem[4];
    bit toggle_rdy;
    int stall_req, stall_left;
    int got_ids[$], got_lens[$], got_lens2[$], exp_ids[$], exp_lens[$];
    bit got_ovf[$], exp_ovf[$];
    int last_done_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        req_vld = '0; req_last = '0; req_a = '0; req_b = '0; rdy = 1'b1; ovf = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic clear_traffic();
        for (int r = 0; r < 4; r++) begin
            plen[r] = 1; pcnt[r] = 0;
        end
        toggle_rdy = 1'b0; stall_req = -1; stall_left = 0;
        exp_ids.delete(); exp_lens.delete();
    endtask

    task automatic run_traffic(input int max_cycles);
        int  ndone, cyc, tot;
        bit  stalled;
        logic [3:0] mask;
        ndone = 0; cyc = 0; tot = 0;
        got_ids.delete(); got_lens.delete(); got_lens2.delete();
        got_ovf.delete(); exp_ovf.delete();
        for (int r = 0; r < 4; r++) begin
            rem[r] = plen[r];
            tot += pcnt[r];
        end
        while (ndone < tot && cyc < max_cycles) begin
            @(posedge clk); #1;
            for (int r = 0; r < 4; r++) begin
                stalled = (r == stall_req) && stall_left > 0 && pcnt[r] > 0
                          && rem[r] == plen[r] - 2;
                if (stalled) stall_left--;
                req_vld[r]  = pcnt[r] > 0 && !stalled;
                req_last[r] = rem[r] == 1;
                req_a[r]    = 1'($urandom_range(0, 1));
                req_b[r]    = 1'($urandom_range(0, 1));
            end
            rdy = toggle_rdy ? (cyc % 3 == 0) : 1'b1;
            ovf = 1'($urandom_range(0, 1));
            #3;
            mask = 4'b0001 << o_id;
            check("rdy_exclusive", req_rdy & ~mask, 4'b0000);
            if (o_vld) begin
                check("fwd_vld", req_vld[o_id], 1'b1);
                check("fwd_last", o_last, req_last[o_id]);
                check("fwd_a", o_a, req_a[o_id]);
                check("fwd_b", o_b, req_b[o_id]);
                check("fwd_rdy", req_rdy[o_id], rdy);
            end
            if (pkt_done) begin
                got_ids.push_back(int'(pkt_id));
                got_lens.push_back(int'(pkt_len));
                got_lens2.push_back(int'(pkt_len2));
                got_ovf.push_back(pkt_ovf);
                ndone++;
                last_done_cyc = cyc;
            end
            if (o_vld && rdy) begin
                if (o_last) exp_ovf.push_back(ovf);
                rem[o_id]--;
                if (rem[o_id] == 0) begin
                    pcnt[o_id]--;
                    rem[o_id] = plen[o_id];
                end
            end
            cyc++;
        end
        if (ndone < tot) begin
            n_checks++; n_errors++;
            $display("FAIL traffic_timeout: got %0d packets, expected %0d", ndone, tot);
        end
        @(posedge clk); #1;
        set_idle();
    endtask

    task automatic compare_run(input string tag);
        int e2;
        check({tag, "_count"}, got_ids.size(), exp_ids.size());
        for (int k = 0; k < exp_ids.size() && k < got_ids.size(); k++) begin
            e2 = exp_lens[k] > 3 ? 3 : exp_lens[k];
            check($sformatf("%s_id%0d", tag, k), got_ids[k], exp_ids[k]);
            check($sformatf("%s_len%0d", tag, k), got_lens[k], exp_lens[k]);
            check($sformatf("%s_satlen%0d", tag, k), got_lens2[k], e2);
            if (k < exp_ovf.size())
                check($sformatf("%s_ovf%0d", tag, k), got_ovf[k], exp_ovf[k]);
        end
    endtask

    initial begin
        // vld  last  a  b  rdy ovf | vld last a b  rdy  id | done pid len povf
        tv[0] = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b1, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0, 8'd0, 1'b0};
        tv[1] = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b1, 1'b1,
                  1'b1, 1'b0, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 2'd0, 8'd0, 1'b0};
        tv[2] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b1,
                  1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b0, 2'd0, 8'd0, 1'b0};
        tv[3] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b1,
                  1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0, 2'd0, 8'd0, 1'b0};
        tv[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1, 2'd0, 8'd3, 1'b1};
        tv[5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0, 8'd3, 1'b1};
        tv[6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0, 8'd3, 1'b1};
        tv[7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0,
                  1'b1, 1'b1, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0, 2'd0, 8'd3, 1'b1};
        tv[8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b1, 2'd2, 8'd1, 1'b0};
        tv[9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 2'd2, 8'd1, 1'b0};

        // Reset values, with every input driven high to prove nothing leaks through.
        req_vld = '1; req_last = '1; req_a = '1; req_b = '1; rdy = 1'b1; ovf = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", o_vld, 1'b0);
        check("rst_last", o_last, 1'b0);
        check("rst_a", o_a, 1'b0);
        check("rst_b", o_b, 1'b0);
        check("rst_rdy", req_rdy, 4'b0000);
        check("rst_id", o_id, 2'd0);
        check("rst_done", pkt_done, 1'b0);
        check("rst_pkt", {pkt_id, pkt_len, pkt_ovf}, 11'd0);
        set_idle();
        @(posedge clk); #1 rst_n = 1'b1;

        // 3-flit packet from req0 then a single-flit packet from req2.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            req_vld = tv[i].vld; req_last = tv[i].last; req_a = tv[i].a; req_b = tv[i].b;
            rdy = tv[i].rdy; ovf = tv[i].ovf;
            #3;
            check($sformatf("tv%0d_vld", i), o_vld, tv[i].e_vld);
            check($sformatf("tv%0d_last", i), o_last, tv[i].e_last);
            check($sformatf("tv%0d_ab", i), {o_a, o_b}, {tv[i].e_a, tv[i].e_b});
            check($sformatf("tv%0d_rdy", i), req_rdy, tv[i].e_rdy);
            check($sformatf("tv%0d_id", i), o_id, tv[i].e_id);
            check($sformatf("tv%0d_done", i), pkt_done, tv[i].e_done);
            check($sformatf("tv%0d_pid", i), pkt_id, tv[i].e_pid);
            check($sformatf("tv%0d_len", i), pkt_len, tv[i].e_len);
            check($sformatf("tv%0d_povf", i), pkt_ovf, tv[i].e_povf);
        end
        set_idle();

        // req1 and req3 together from reset: 1 then 3, one bubble each.
        do_reset();
        clear_traffic();
        plen[1] = 2; pcnt[1] = 1; plen[3] = 2; pcnt[3] = 1;
        exp_ids = '{1, 3}; exp_lens = '{2, 2};
        run_traffic(100);
        compare_run("pair");
        check("pair_cycles", last_done_cyc, 6);

        // req2 streaming against req0: strict alternation.
        do_reset();
        clear_traffic();
        plen[0] = 2; pcnt[0] = 2; plen[2] = 4; pcnt[2] = 2;
        exp_ids = '{0, 2, 0, 2}; exp_lens = '{2, 4, 2, 4};
        run_traffic(200);
        compare_run("alt");
        check("alt_cycles", last_done_cyc, 16);

        // req1 5-flit packet with back-pressure and a 2-cycle source stall; others waiting.
        do_reset();
        clear_traffic();
        plen[1] = 5; pcnt[1] = 1; plen[2] = 1; pcnt[2] = 1; plen[3] = 1; pcnt[3] = 1;
        toggle_rdy = 1'b1; stall_req = 1; stall_left = 2;
        exp_ids = '{1, 2, 3}; exp_lens = '{5, 1, 1};
        run_traffic(300);
        compare_run("stall");
        check("stall_used", stall_left, 0);

        // 6-flit packet: wide counter reports 6, 2-bit counter saturates at 3.
        do_reset();
        clear_traffic();
        plen[0] = 6; pcnt[0] = 1;
        exp_ids = '{0}; exp_lens = '{6};
        run_traffic(100);
        compare_run("sat");

        // Reset after two accepted flits of a 4-flit packet.
        @(posedge clk); #1;
        req_vld = 4'b0001; req_last = 4'b0000; rdy = 1'b1;
        #3 check("mr_idle_vld", o_vld, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #4;
            check($sformatf("mr_flit%0d", i), {o_vld, o_id}, {1'b1, 2'd0});
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mr_rst_vld", o_vld, 1'b0);
        check("mr_rst_rdy", req_rdy, 4'b0000);
        check("mr_rst_done", pkt_done, 1'b0);
        check("mr_rst_len", pkt_len, 8'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #3 check("mr_rel_vld", o_vld, 1'b0);
        check("mr_rel_done", pkt_done, 1'b0);
        @(posedge clk); #4;
        check("mr_regrant", {o_vld, o_id, req_rdy}, {1'b1, 2'd0, 4'b0001});
        check("mr_no_done", pkt_done, 1'b0);
        set_idle();
        @(posedge clk); #4;
        check("mr_no_done2", pkt_done, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bitser_rr_arbiter.md
Name: bitser_rr_arbiter

Overview:
Packet-granular round-robin arbiter that shares one bit-serial adder stream port between N_REQ requester streams. A grant is held from a packet's first flit through its last flit, so a packet is never interleaved with another requester's flits. The arbiter tags the active stream with the requester ID for downstream demux. On packet completion it reports per-packet status: ID, flit count, and the adder's overflow flag. It sits between the requester stream sources and the adder input; the adder's overflow output feeds back into it.

Parameters:
N_REQ, 4, number of requester streams (2..16)
ID_W, 2, requester ID width; must satisfy 2**ID_W >= N_REQ
LEN_W, 8, packet flit-count width; the count saturates at 2**LEN_W-1

Ports:
i_clk  in  1  clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_req_A  in  N_REQ  per-requester operand A bit
i_req_B  in  N_REQ  per-requester operand B bit
i_req_vld  in  N_REQ  per-requester flit valid
i_req_last  in  N_REQ  per-requester last-flit marker
o_req_rdy  out  N_REQ  per-requester ready
o_A  out  1  operand A to adder
o_B  out  1  operand B to adder
o_vld  out  1  flit valid to adder
o_last  out  1  last flit to adder
i_rdy  in  1  adder ready
o_id  out  ID_W  ID of the granted requester (tags the current flit)
i_ovf  in  1  adder overflow; sampled only on the last-flit handshake
o_pkt_done  out  1  one-cycle pulse after a packet's last flit is accepted
o_pkt_id  out  ID_W  ID of the completed packet
o_pkt_len  out  LEN_W  flits in the completed packet, including the last flit
o_pkt_ovf  out  1  overflow captured for the completed packet

Behaviour:
- Reset: one clock, i_clk; reset is asynchronous and active-low (i_reset_n). Reset forces the following values:
  - state=IDLE, ptr=N_REQ-1, grant=0, flit counter=0.
  - o_pkt_done=0, o_pkt_id=0, o_pkt_len=0, o_pkt_ovf=0.
  - Combinational outputs during reset: o_vld=0, o_last=0, o_A=0, o_B=0, o_req_rdy=0, o_id=grant.
- Handshake: a flit transfers when o_vld & i_rdy are both high.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - o_vld=0 and all o_req_rdy=0.
  - If any i_req_vld is set, select the first set bit searching from (ptr+1) mod N_REQ upward with wrap.
  - Register the selected index into grant and go to BUSY.
  - Result: exactly one bubble cycle before each packet, and requester 0 wins the first arbitration after reset.
- BUSY, combinational routing of the granted requester g:
  - o_A=i_req_A[g], o_B=i_req_B[g], o_vld=i_req_vld[g], o_last=i_req_last[g].
  - o_req_rdy[g]=i_rdy; o_req_rdy of every other requester is 0; o_id=g.
- BUSY, per handshake:
  - The flit counter increments, saturating at 2**LEN_W-1.
  - Deasserting i_req_vld[g] mid-packet holds the grant; stalls are unbounded.
  - i_rdy low holds all state.
- BUSY, last-flit handshake (i_req_last[g]):
  - Next cycle: o_pkt_done=1, o_pkt_id=g, o_pkt_len=counter+1 (saturated), o_pkt_ovf=i_ovf as sampled in the handshake cycle.
  - Also: ptr<=g, counter<=0, state<=IDLE.
- o_pkt_done lasts exactly one cycle. o_pkt_id, o_pkt_len and o_pkt_ovf hold until the next completion.
- A single-flit packet (last on the first flit) gives o_pkt_len=1.
- Requests from other requesters during BUSY are ignored until IDLE. A requester that just finished has the lowest priority in the next arbitration.
- Reset mid-packet: the packet is abandoned with no o_pkt_done, and arbitration restarts from ptr=N_REQ-1.
- A non-granted requester's vld/last are never forwarded.
- Only the sampled ptr, grant, counter and status registers are state; everything else is combinational.

Test Plan:
- Reset release, then req0 sends a 3-flit packet with i_rdy=1, A=101b, B=011b LSB-first:
  - Expected: o_vld rises one cycle after req0 vld, with o_id=0.
  - Expected: o_pkt_done one cycle after the last flit, o_pkt_len=3, o_pkt_ovf=1 (i_ovf driven 1 by the adder model).
- req1 and req3 valid simultaneously from reset, 2-flit packets each:
  - Expected grant order 1 then 3, one bubble cycle between them.
  - Expected o_req_rdy[3]=0 throughout req1's packet.
- req2 streams continuous 4-flit packets while req0 also requests:
  - Expected grants alternate 0,2,0,2.
  - req2 never wins twice in a row while req0 is pending.
- Granted req1 sends a 5-flit packet with i_rdy toggling 1,0,0,1,…, plus 2 cycles of i_req_vld[1]=0 mid-packet:
  - Expected: the grant is held, o_pkt_len=5, and no foreign flit appears on o_vld.
- i_reset_n asserted after 2 of 4 flits of req0's packet:
  - Expected: outputs immediately at reset values, no o_pkt_done.
  - Expected: after release, req0 wins again if it is the sole requester.
- LEN_W=2, 6-flit packet:
  - Expected o_pkt_len=3 (saturated).
- Single-flit packet with i_ovf=0:
  - Expected o_pkt_len=1, o_pkt_ovf=0.
